gb_csr_responder: RTL and testbench



---
 rtl/gb_csr_responder.sv | 116 +++++++++++
 tb/tb_gb_csr_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_csr_responder.sv
// Ghostbus leaf responder: CTRL/WCOUNT/RCOUNT registers plus an optional 8-byte RAM window.
// Define GB_CSR_RESPONDER_RAM_EN to build the RAM at offsets 0x8..0xF; otherwise those offsets are reserved.
module gb_csr_responder #(
    parameter int              AW         = 24,
    parameter int              DW         = 32,
    parameter logic [AW-1:0]   BASE       = 24'h000040,
    parameter int              READ_DELAY = 3
) (
    input  logic          gb_clk,
    input  logic          gb_rst_n,
    input  logic [AW-1:0] gb_addr,
    input  logic [DW-1:0] gb_wdata,
    input  logic          gb_wen,
    input  logic          gb_rstb,
    output logic [DW-1:0] gb_rdata,
    output logic          gb_rvalid,
    output logic [7:0]    ctrl_out
);

    logic        hit;
    logic [3:0]  off;
    logic        wr_hit;
    logic        rd_hit;
    logic [15:0] wcount;
    logic [15:0] rcount;
    logic [15:0] rd_val;
    logic        unused_wdata;

    logic [READ_DELAY-1:0] pipe_v;
    logic [READ_DELAY-1:0] pipe_h;
    logic [DW-1:0]         pipe_d [READ_DELAY];

    assign hit          = (gb_addr[AW-1:4] == BASE[AW-1:4]);
    assign off          = gb_addr[3:0];
    assign wr_hit       = gb_wen & hit;
    assign rd_hit       = gb_rstb & hit;
    assign unused_wdata = ^gb_wdata[DW-1:8];

`ifdef GB_CSR_RESPONDER_RAM_EN
    logic [7:0] ram [8];

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            for (int i = 0; i < 8; i++) ram[i] <= 8'h00;
        end else if (wr_hit && off[3]) begin
            ram[off[2:0]] <= gb_wdata[7:0];
        end
    end
`endif

    // Read word is taken from current (pre-write) state, so a same-cycle write is not visible.
    always_comb begin
        rd_val = '0;
        if (hit) begin
            case (off)
                4'h0:    rd_val = {8'h00, ctrl_out};
                4'h1:    rd_val = wcount;
                4'h2:    rd_val = rcount;
                default: begin
`ifdef GB_CSR_RESPONDER_RAM_EN
                    if (off[3]) rd_val = {8'h00, ram[off[2:0]]};
`endif
                end
            endcase
        end
    end

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            ctrl_out <= 8'h00;
        end else if (wr_hit && off == 4'h0) begin
            ctrl_out <= gb_wdata[7:0];
        end
    end

    // A write to a counter clears it and wins over any same-cycle increment.
    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            wcount <= 16'h0000;
            rcount <= 16'h0000;
        end else begin
            if (wr_hit && off == 4'h1)
                wcount <= 16'h0000;
            else if (wr_hit && wcount != 16'hFFFF)
                wcount <= wcount + 16'h0001;

            if (wr_hit && off == 4'h2)
                rcount <= 16'h0000;
            else if (rd_hit && rcount != 16'hFFFF)
                rcount <= rcount + 16'h0001;
        end
    end

    always_ff @(posedge gb_clk or negedge gb_rst_n) begin
        if (!gb_rst_n) begin
            pipe_v    <= '0;
            pipe_h    <= '0;
            for (int i = 0; i < READ_DELAY; i++) pipe_d[i] <= '0;
            gb_rvalid <= 1'b0;
            gb_rdata  <= '0;
        end else begin
            pipe_v[0] <= gb_rstb;
            pipe_h[0] <= rd_hit;
            pipe_d[0] <= DW'(rd_val);
            for (int i = 1; i < READ_DELAY; i++) begin
                pipe_v[i] <= pipe_v[i-1];
                pipe_h[i] <= pipe_h[i-1];
                pipe_d[i] <= pipe_d[i-1];
            end
            gb_rvalid <= pipe_v[READ_DELAY-1] & pipe_h[READ_DELAY-1];
            // Misses carry zero data, so a completed miss read drives 0.
            if (pipe_v[READ_DELAY-1]) gb_rdata <= pipe_d[READ_DELAY-1];
        end
    end

endmodule

// File: tb/tb_gb_csr_responder.sv
// Self-checking bench for gb_csr_responder: directed table, corner sequences and random traffic
// against a queue-based reference model. Follows GB_CSR_RESPONDER_RAM_EN to know whether RAM exists.
module tb_gb_csr_responder;

    localparam int          RD   = 3;
    localparam logic [23:0] BASE = 24'h000040;
`ifdef GB_CSR_RESPONDER_RAM_EN
    localparam bit RAM_EN = 1'b1;
`else
    localparam bit RAM_EN = 1'b0;
`endif

    logic        gb_clk;
    logic        gb_rst_n;
    logic [23:0] gb_addr;
    logic [31:0] gb_wdata;
    logic        gb_wen;
    logic        gb_rstb;
    logic [31:0] gb_rdata;
    logic        gb_rvalid;
    logic [7:0]  ctrl_out;

    gb_csr_responder #(.AW(24), .DW(32), .BASE(BASE), .READ_DELAY(RD)) dut (
        .gb_clk   (gb_clk),
        .gb_rst_n (gb_rst_n),
        .gb_addr  (gb_addr),
        .gb_wdata (gb_wdata),
        .gb_wen   (gb_wen),
        .gb_rstb  (gb_rstb),
        .gb_rdata (gb_rdata),
        .gb_rvalid(gb_rvalid),
        .ctrl_out (ctrl_out)
    );

    initial gb_clk = 1'b0;
    always #5 gb_clk = ~gb_clk;

    typedef struct {
        int          due;
        bit          hit;
        logic [31:0] data;
    } pend_t;

    typedef struct {
        bit          wen;
        bit          rstb;
        logic [3:0]  off;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    pend_t pq[$];
    vec_t  vecs[$];

    logic [7:0]  m_ctrl;
    int          m_wcount;
    int          m_rcount;
    logic [7:0]  m_ram [8];
    int          cyc;
    bit          exp_rvalid;
    logic [31:0] exp_rdata;
    int          n_checks;
    int          n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_ctrl   = 8'h00;
        m_wcount = 0;
        m_rcount = 0;
        for (int i = 0; i < 8; i++) m_ram[i] = 8'h00;
        pq.delete();
        exp_rvalid = 1'b0;
        exp_rdata  = 32'h0;
    endtask

    task automatic compare_outputs();
        pend_t p;
        exp_rvalid = 1'b0;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            p          = pq.pop_front();
            exp_rvalid = p.hit;
            exp_rdata  = p.data;
        end
        check("rvalid", 32'(gb_rvalid), 32'(exp_rvalid));
        check("rdata", gb_rdata, exp_rdata);
        check("ctrl_out", 32'(ctrl_out), 32'(m_ctrl));
    endtask

    // One bus cycle: drive, update the model at the edge, compare 1 ns later.
    task automatic step(input bit wen, input bit rstb, input logic [23:0] addr, input logic [31:0] wdata);
        bit          hit;
        logic [3:0]  off;
        logic [31:0] rv;
        pend_t       p;
        gb_wen   = wen;
        gb_rstb  = rstb;
        gb_addr  = addr;
        gb_wdata = wdata;
        hit = (addr[23:4] == BASE[23:4]);
        off = addr[3:0];
        rv  = 32'h0;
        if (hit) begin
            if (off == 4'h0)               rv = {24'h0, m_ctrl};
            else if (off == 4'h1)          rv = m_wcount;
            else if (off == 4'h2)          rv = m_rcount;
            else if (off[3] && RAM_EN)     rv = {24'h0, m_ram[off[2:0]]};
        end
        @(posedge gb_clk);
        cyc++;
        if (rstb) begin
            p.due  = cyc + RD;
            p.hit  = hit;
            p.data = rv;
            pq.push_back(p);
            if (hit && m_rcount < 65535) m_rcount++;
        end
        if (wen && hit) begin
            if (off == 4'h0) m_ctrl = wdata[7:0];
            if (off == 4'h2) m_rcount = 0;
            if (off[3])      m_ram[off[2:0]] = wdata[7:0];
            if (off == 4'h1) m_wcount = 0;
            else if (m_wcount < 65535) m_wcount++;
        end
        #1;
        gb_wen  = 1'b0;
        gb_rstb = 1'b0;
        compare_outputs();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 24'h000000, 32'h0);
    endtask

    task automatic read_check(input string name, input logic [3:0] off, input logic [31:0] exp);
        step(1'b0, 1'b1, BASE | {20'h0, off}, 32'h0);
        repeat (RD) idle();
        check(name, gb_rdata, exp);
        check({name, "_valid"}, 32'(gb_rvalid), 32'h1);
    endtask

    task automatic add(input bit wen, input bit rstb, input logic [3:0] off,
                       input logic [31:0] wdata, input logic [31:0] exp);
        vec_t v;
        v.wen = wen; v.rstb = rstb; v.off = off; v.wdata = wdata; v.exp = exp;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0]  roff;
        logic [23:0] raddr;
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        gb_rst_n = 1'b0;
        gb_wen   = 1'b0;
        gb_rstb  = 1'b0;
        gb_addr  = 24'h0;
        gb_wdata = 32'h0;
        model_reset();
        repeat (2) @(posedge gb_clk);
        #1;
        check("reset_rdata", gb_rdata, 32'h0);
        check("reset_rvalid", 32'(gb_rvalid), 32'h0);
        check("reset_ctrl", 32'(ctrl_out), 32'h0);
        gb_rst_n = 1'b1;

        // Post-reset reads, register/RAM fill, read-back and same-cycle write+read.
        add(1'b0, 1'b1, 4'h2, 32'h0, 32'h0);
        add(1'b0, 1'b1, 4'h0, 32'h0, 32'h0);
        add(1'b0, 1'b1, 4'h1, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 4'(8 + i), 32'h0, 32'h0);
        add(1'b1, 1'b0, 4'h2, 32'h0, 32'h0);
        add(1'b1, 1'b0, 4'h1, 32'h0, 32'h0);
        add(1'b1, 1'b0, 4'h0, 32'h0000_00CC, 32'h0);
        for (int i = 0; i < 8; i++) add(1'b1, 1'b0, 4'(8 + i), 32'(8'hE8 + i), 32'h0);
        for (int i = 0; i < 8; i++) add(1'b0, 1'b1, 4'(8 + i), 32'h0, RAM_EN ? 32'(8'hE8 + i) : 32'h0);
        add(1'b0, 1'b1, 4'h2, 32'h0, 32'd8);
        add(1'b0, 1'b1, 4'h1, 32'h0, 32'd9);
        add(1'b0, 1'b1, 4'h0, 32'h0, 32'h0000_00CC);
        add(1'b1, 1'b1, 4'h0, 32'h0000_0055, 32'h0000_00CC);
        add(1'b0, 1'b1, 4'h0, 32'h0, 32'h0000_0055);

        foreach (vecs[k]) begin
            step(vecs[k].wen, vecs[k].rstb, BASE | {20'h0, vecs[k].off}, vecs[k].wdata);
            if (vecs[k].rstb) begin
                repeat (RD) idle();
                check("vec_rdata", gb_rdata, vecs[k].exp);
                check("vec_rvalid", 32'(gb_rvalid), 32'h1);
            end
        end
        check("ctrl_after_table", 32'(ctrl_out), 32'h55);

        // Back-to-back reads: CTRL, RAM[0], then a miss.
        step(1'b0, 1'b1, BASE, 32'h0);
        step(1'b0, 1'b1, BASE | 24'h8, 32'h0);
        step(1'b0, 1'b1, BASE + 24'h10, 32'h0);
        idle();
        check("b2b_0_data", gb_rdata, 32'h55);
        check("b2b_0_valid", 32'(gb_rvalid), 32'h1);
        idle();
        check("b2b_1_data", gb_rdata, RAM_EN ? 32'hE8 : 32'h0);
        check("b2b_1_valid", 32'(gb_rvalid), 32'h1);
        idle();
        check("b2b_2_data", gb_rdata, 32'h0);
        check("b2b_2_valid", 32'(gb_rvalid), 32'h0);

        step(1'b1, 1'b0, BASE | 24'h8, 32'h0000_00AA);
        read_check("ram8_aa", 4'h8, RAM_EN ? 32'hAA : 32'h0);

        // WCOUNT saturation and clear.
        repeat (65537) step(1'b1, 1'b0, BASE | 24'h3, 32'h0);
        read_check("wcount_sat", 4'h1, 32'h0000_FFFF);
        step(1'b1, 1'b0, BASE | 24'h1, 32'h0);
        read_check("wcount_clr", 4'h1, 32'h0);

        // Reset one cycle after a read strobe discards the in-flight read.
        step(1'b0, 1'b1, BASE, 32'h0);
        idle();
        gb_rst_n = 1'b0;
        #1;
        model_reset();
        check("rst_mid_rdata", gb_rdata, 32'h0);
        check("rst_mid_rvalid", 32'(gb_rvalid), 32'h0);
        check("rst_mid_ctrl", 32'(ctrl_out), 32'h0);
        repeat (2) begin
            @(posedge gb_clk);
            cyc++;
        end
        #1;
        gb_rst_n = 1'b1;
        repeat (RD + 2) begin
            idle();
            check("rst_no_rvalid", 32'(gb_rvalid), 32'h0);
        end
        read_check("rst_ctrl", 4'h0, 32'h0);
        read_check("rst_ram", 4'h8, 32'h0);

        // Random traffic against the model.
        repeat (2000) begin
            roff  = 4'($urandom_range(0, 15));
            raddr = ($urandom_range(0, 7) == 0) ? 24'($urandom) : (BASE | {20'h0, roff});
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), raddr, $urandom);
        end
        repeat (RD + 2) idle();
        check("drain_empty", 32'(pq.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
